// File: rtl/icache_ctrl_if.sv
// Bundle of the core fetch port, external memory bus and cache memory
// wrapper signals seen by icache_ctrl (slave) and its environment (master).
interface icache_ctrl_if #(
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 22
);
    // Handshakes: core side, a read is accepted in the cycle where req_i and gnt_o
    // are both high, and the word returns later as a one-cycle rvalid_o pulse.
    // Bus side, mem_req_o/mem_addr_o are held until the cycle with mem_gnt_i high,
    // then exactly one mem_rvalid_i pulse carries the data; one beat in flight.
    logic                  flush_i;
    logic                  busy_o;
    logic                  req_i;
    logic [31:0]           addr_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [31:0]           rdata_o;
    logic                  mem_req_o;
    logic [31:0]           mem_addr_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [31:0]           mem_rdata_i;
    logic [SET_BITS-1:0]   cm_set_o;
    logic                  cm_way_o;
    logic                  cm_enable_o;
    logic                  cm_write_enable_o;
    logic                  cm_val_write_enable_o;
    logic                  cm_line_valid_o;
    logic [TAG_BITS-1:0]   cm_line_tag_o;
    logic [127:0]          cm_line_o;
    logic [3:0]            cm_ww_enable_o;
    logic [1:0]            cm_line_valid_i;
    logic [2*TAG_BITS-1:0] cm_line_tag_i;
    logic [127:0]          cm_line_i;

    modport slave (
        input  flush_i, req_i, addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
               cm_line_valid_i, cm_line_tag_i, cm_line_i,
        output busy_o, gnt_o, rvalid_o, rdata_o, mem_req_o, mem_addr_o,
               cm_set_o, cm_way_o, cm_enable_o, cm_write_enable_o,
               cm_val_write_enable_o, cm_line_valid_o, cm_line_tag_o,
               cm_line_o, cm_ww_enable_o
    );

    modport master (
        output flush_i, req_i, addr_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
               cm_line_valid_i, cm_line_tag_i, cm_line_i,
        input  busy_o, gnt_o, rvalid_o, rdata_o, mem_req_o, mem_addr_o,
               cm_set_o, cm_way_o, cm_enable_o, cm_write_enable_o,
               cm_val_write_enable_o, cm_line_valid_o, cm_line_tag_o,
               cm_line_o, cm_ww_enable_o
    );
endinterface

// File: rtl/icache_ctrl.sv
// Read-only 2-way instruction cache controller: tag lookup, hit return,
// 4-beat LRU refill on miss and a full invalidate sweep after reset or flush.
module icache_ctrl #(
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 22
) (
    input  logic          clk,
    input  logic          reset,
    icache_ctrl_if.slave  bus,
    output logic [2:0]    o_dbg_state
);
    typedef enum logic [2:0] {
        S_FLUSH  = 3'd0,
        S_IDLE   = 3'd1,
        S_TAG    = 3'd2,
        S_DATA   = 3'd3,
        S_REFILL = 3'd4,
        S_WRITE  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SET_BITS:0]      r_flush_cnt;
    logic [31:0]            r_addr;
    logic [2**SET_BITS-1:0] r_lru;
    logic                   r_victim;
    logic [1:0]             r_beat;
    logic                   r_granted;
    logic [127:0]           r_buf;

    logic [TAG_BITS-1:0]    w_tag;
    logic [SET_BITS-1:0]    w_set;
    logic [1:0]             w_word;
    logic                   w_hit0;
    logic                   w_hit1;
    logic                   w_hit;
    logic                   w_hit_way;
    logic                   w_miss_victim;

    assign w_tag  = r_addr[31 -: TAG_BITS];
    assign w_set  = r_addr[4 +: SET_BITS];
    assign w_word = r_addr[3:2];

    assign w_hit0    = bus.cm_line_valid_i[0] && (bus.cm_line_tag_i[0 +: TAG_BITS] == w_tag);
    assign w_hit1    = bus.cm_line_valid_i[1] && (bus.cm_line_tag_i[TAG_BITS +: TAG_BITS] == w_tag);
    assign w_hit     = w_hit0 || w_hit1;
    assign w_hit_way = !w_hit0;
    // Fill an empty way before evicting anything; LRU only decides between two valid lines.
    assign w_miss_victim = !bus.cm_line_valid_i[0] ? 1'b0 :
                           !bus.cm_line_valid_i[1] ? 1'b1 : r_lru[w_set];

    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FLUSH;
            r_flush_cnt <= '0;
            r_addr      <= '0;
            r_lru       <= '0;
            r_victim    <= 1'b0;
            r_beat      <= 2'd0;
            r_granted   <= 1'b0;
            r_buf       <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    r_lru       <= '0;
                end
                S_IDLE: begin
                    if (bus.flush_i) begin
                        r_flush_cnt <= '0;
                    end else if (bus.req_i) begin
                        r_addr <= bus.addr_i;
                    end
                end
                S_TAG: begin
                    if (w_hit) begin
                        r_lru[w_set] <= ~w_hit_way;
                    end else begin
                        r_victim  <= w_miss_victim;
                        r_beat    <= 2'd0;
                        r_granted <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (!r_granted) begin
                        if (bus.mem_gnt_i) begin
                            r_granted <= 1'b1;
                        end
                    end else if (bus.mem_rvalid_i) begin
                        r_buf[{r_beat, 5'b00000} +: 32] <= bus.mem_rdata_i;
                        r_beat    <= r_beat + 2'd1;
                        r_granted <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_lru[w_set] <= ~r_victim;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state              = r_state;
        bus.busy_o                = reset || (r_state != S_IDLE);
        bus.gnt_o                 = 1'b0;
        bus.rvalid_o              = 1'b0;
        bus.rdata_o               = '0;
        bus.mem_req_o             = 1'b0;
        bus.mem_addr_o            = '0;
        bus.cm_set_o              = '0;
        bus.cm_way_o              = 1'b0;
        bus.cm_enable_o           = 1'b0;
        bus.cm_write_enable_o     = 1'b0;
        bus.cm_val_write_enable_o = 1'b0;
        bus.cm_line_valid_o       = 1'b0;
        bus.cm_line_tag_o         = '0;
        bus.cm_line_o             = '0;
        bus.cm_ww_enable_o        = 4'h0;

        case (r_state)
            S_FLUSH: begin
                bus.cm_enable_o           = 1'b1;
                bus.cm_val_write_enable_o = 1'b1;
                bus.cm_set_o              = r_flush_cnt[SET_BITS:1];
                bus.cm_way_o              = r_flush_cnt[0];
                if (r_flush_cnt == '1) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.flush_i) begin
                    w_next_state = S_FLUSH;
                end else if (bus.req_i) begin
                    bus.gnt_o       = 1'b1;
                    bus.cm_enable_o = 1'b1;
                    bus.cm_set_o    = bus.addr_i[4 +: SET_BITS];
                    w_next_state    = S_TAG;
                end
            end
            S_TAG: begin
                if (w_hit) begin
                    bus.cm_enable_o = 1'b1;
                    bus.cm_set_o    = w_set;
                    bus.cm_way_o    = w_hit_way;
                    w_next_state    = S_DATA;
                end else begin
                    w_next_state = S_REFILL;
                end
            end
            S_DATA: begin
                bus.rvalid_o = 1'b1;
                bus.rdata_o  = bus.cm_line_i[{w_word, 5'b00000} +: 32];
                w_next_state = S_IDLE;
            end
            S_REFILL: begin
                bus.mem_req_o  = !r_granted;
                bus.mem_addr_o = {w_tag, w_set, r_beat, 2'b00};
                if (r_granted && bus.mem_rvalid_i && (r_beat == 2'd3)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.cm_enable_o       = 1'b1;
                bus.cm_write_enable_o = 1'b1;
                bus.cm_set_o          = w_set;
                bus.cm_way_o          = r_victim;
                bus.cm_line_valid_o   = 1'b1;
                bus.cm_line_tag_o     = w_tag;
                bus.cm_line_o         = r_buf;
                bus.cm_ww_enable_o    = 4'hF;
                bus.rvalid_o          = 1'b1;
                bus.rdata_o           = r_buf[{w_word, 5'b00000} +: 32];
                w_next_state          = S_IDLE;
            end
            default: begin
                w_next_state = S_FLUSH;
            end
        endcase

        // Reset must show quiet outputs even though the state register only updates at the edge.
        if (reset) begin
            bus.gnt_o                 = 1'b0;
            bus.rvalid_o              = 1'b0;
            bus.rdata_o               = '0;
            bus.mem_req_o             = 1'b0;
            bus.mem_addr_o            = '0;
            bus.cm_enable_o           = 1'b0;
            bus.cm_write_enable_o     = 1'b0;
            bus.cm_val_write_enable_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: cache-memory and bus models, directed reads with
// hand-computed words, and a scoreboard fed by the driver and drained by a monitor.
module tb_icache_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    icache_ctrl_if bus_if ();

    icache_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .o_dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Cache memory model: one-cycle read latency, preloaded with stale valid lines.
    logic         cm_valid [2][64];
    logic [21:0]  cm_tag   [2][64];
    logic [127:0] cm_data  [2][64];
    logic         cm_preloaded = 1'b0;
    logic [1:0]   rd_valid;
    logic [43:0]  rd_tag;
    logic [127:0] rd_line;

    always @(posedge clk) begin
        if (!cm_preloaded) begin
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < 64; s++) begin
                    cm_valid[w][s] <= 1'b1;
                    cm_tag[w][s]   <= 22'd0;
                    cm_data[w][s]  <= {4{32'hDEADBEEF}};
                end
            end
            cm_preloaded <= 1'b1;
        end else if (bus_if.cm_enable_o) begin
            rd_valid <= {cm_valid[1][bus_if.cm_set_o], cm_valid[0][bus_if.cm_set_o]};
            rd_tag   <= {cm_tag[1][bus_if.cm_set_o], cm_tag[0][bus_if.cm_set_o]};
            rd_line  <= cm_data[bus_if.cm_way_o][bus_if.cm_set_o];
            if (bus_if.cm_write_enable_o) begin
                cm_valid[bus_if.cm_way_o][bus_if.cm_set_o] <= bus_if.cm_line_valid_o;
                cm_tag[bus_if.cm_way_o][bus_if.cm_set_o]   <= bus_if.cm_line_tag_o;
                for (int k = 0; k < 4; k++) begin
                    if (bus_if.cm_ww_enable_o[k])
                        cm_data[bus_if.cm_way_o][bus_if.cm_set_o][32*k +: 32] <= bus_if.cm_line_o[32*k +: 32];
                end
            end else if (bus_if.cm_val_write_enable_o) begin
                cm_valid[bus_if.cm_way_o][bus_if.cm_set_o] <= bus_if.cm_line_valid_o;
            end
        end
    end

    assign bus_if.cm_line_valid_i = rd_valid;
    assign bus_if.cm_line_tag_i   = rd_tag;
    assign bus_if.cm_line_i       = rd_line;

    // Bus model: grant immediately (or after 3 cycles on beat 2), data the next cycle.
    int            req_age = 0;
    logic          delay_beat2 = 1'b0;
    logic [31:0]   mem_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        case (a[3:2])
            2'd0:    b = 8'h11;
            2'd1:    b = 8'h22;
            2'd2:    b = 8'h33;
            default: b = 8'h44;
        endcase
        return {a[25:10], 8'h00, b};
    endfunction

    assign bus_if.mem_gnt_i = bus_if.mem_req_o &&
        (req_age >= ((delay_beat2 && bus_if.mem_addr_o[3:2] == 2'd2) ? 3 : 0));

    always @(posedge clk) begin
        if (bus_if.mem_req_o && !bus_if.mem_gnt_i) req_age <= req_age + 1;
        else req_age <= 0;
        bus_if.mem_rvalid_i <= bus_if.mem_req_o && bus_if.mem_gnt_i;
        bus_if.mem_rdata_i  <= mem_word(bus_if.mem_addr_o);
        if (bus_if.mem_req_o && bus_if.mem_gnt_i) mem_log.push_back(bus_if.mem_addr_o);
    end

    // Scoreboard and monitor.
    logic [31:0] exp_q[$];
    logic [31:0] wr_q[$];
    int          rv_count = 0;
    int          rv_cyc = 0;
    int          memreq_cyc = 0;
    int          busy_run = 0;
    int          last_busy_run = 0;
    int          flush_clears = 0;
    bit          flush_seen[128];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if (bus_if.rvalid_o) begin
            rv_count++;
            rv_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rvalid_unexpected: got rdata 0x%08h, expected no response", bus_if.rdata_o);
            end else begin
                check("rdata", bus_if.rdata_o, exp_q.pop_front());
            end
        end
        if (bus_if.gnt_o) check("gnt_only_in_idle", 32'(dbg_state), 32'd1);
        if (prev_stall && !reset) begin
            check("mem_req_held", 32'(bus_if.mem_req_o), 32'd1);
            check("mem_addr_stable", bus_if.mem_addr_o, prev_addr);
        end
        prev_stall = bus_if.mem_req_o && !bus_if.mem_gnt_i && !reset;
        prev_addr  = bus_if.mem_addr_o;
        if (bus_if.cm_val_write_enable_o) begin
            if (bus_if.cm_set_o == 6'd0 && bus_if.cm_way_o == 1'b0) begin
                flush_clears = 0;
                for (int i = 0; i < 128; i++) flush_seen[i] = 1'b0;
            end
            if (!bus_if.cm_line_valid_o && !flush_seen[{bus_if.cm_set_o, bus_if.cm_way_o}]) begin
                flush_seen[{bus_if.cm_set_o, bus_if.cm_way_o}] = 1'b1;
                flush_clears++;
            end
        end
        if (bus_if.cm_write_enable_o) begin
            check("write_line_valid", 32'(bus_if.cm_line_valid_o), 32'd1);
            check("write_ww_enable", 32'(bus_if.cm_ww_enable_o), 32'hF);
            wr_q.push_back({3'b000, bus_if.cm_way_o, bus_if.cm_set_o, bus_if.cm_line_tag_o});
        end
        if (bus_if.mem_req_o) memreq_cyc++;
        if (reset) busy_run = 0;
        else if (bus_if.busy_o) busy_run++;
        else if (busy_run != 0) begin
            last_busy_run = busy_run;
            busy_run = 0;
        end
    end

    // Driver tasks.
    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk); #1;
            if (!bus_if.busy_o) done = 1'b1;
        end
        if (!done) fail_now({name, "_idle"});
        else begin
            check({name, "_busy_cycles"}, 32'(last_busy_run), 32'd128);
            check({name, "_flush_clears"}, 32'(flush_clears), 32'd128);
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_if.req_i = 1'b0;
        bus_if.flush_i = 1'b0;
        @(negedge clk); #1;
        check("rst_busy", 32'(bus_if.busy_o), 32'd1);
        check("rst_gnt", 32'(bus_if.gnt_o), 32'd0);
        check("rst_rvalid", 32'(bus_if.rvalid_o), 32'd0);
        check("rst_rdata", bus_if.rdata_o, 32'd0);
        check("rst_mem_req", 32'(bus_if.mem_req_o), 32'd0);
        check("rst_mem_addr", bus_if.mem_addr_o, 32'd0);
        check("rst_cm_enables", {29'd0, bus_if.cm_enable_o, bus_if.cm_write_enable_o,
                                 bus_if.cm_val_write_enable_o}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_idle(name);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp,
                           input bit with_flush, output int lat);
        bit got = 1'b0;
        int g = 0;
        int rv0;
        lat = 0;
        @(posedge clk); #1;
        bus_if.req_i  = 1'b1;
        bus_if.addr_i = a;
        if (with_flush) begin
            bus_if.flush_i = 1'b1;
            @(negedge clk); #1;
            check("flush_blocks_gnt", 32'(bus_if.gnt_o), 32'd0);
            @(posedge clk); #1;
            bus_if.flush_i = 1'b0;
        end
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk); #1;
            if (bus_if.gnt_o) got = 1'b1;
        end
        if (!got) begin
            fail_now("gnt_wait");
            bus_if.req_i = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        g   = cyc;
        rv0 = rv_count;
        @(posedge clk); #1;
        bus_if.req_i = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk); #1;
            if (rv_count != rv0) got = 1'b1;
        end
        if (!got) fail_now("rvalid_wait");
        else lat = rv_cyc - g;
    endtask

    task automatic miss_read(input logic [31:0] a, input logic [31:0] exp,
                             input logic exp_way, input bit with_flush);
        int mb = mem_log.size();
        int wb = wr_q.size();
        int lat;
        logic [31:0] line = {a[31:4], 4'h0};
        do_read(a, exp, with_flush, lat);
        check("miss_beats", 32'(mem_log.size() - mb), 32'd4);
        if (mem_log.size() - mb == 4) begin
            for (int i = 0; i < 4; i++) check("miss_beat_addr", mem_log[mb + i], line + 32'(4 * i));
        end
        check("miss_writes", 32'(wr_q.size() - wb), 32'd1);
        if (wr_q.size() - wb == 1)
            check("miss_way_set_tag", wr_q[wb], {3'b000, exp_way, a[9:4], a[31:10]});
        if (!with_flush && !delay_beat2) check("miss_latency", 32'(lat), 32'd10);
    endtask

    task automatic hit_read(input logic [31:0] a, input logic [31:0] exp);
        int mq = memreq_cyc;
        int wb = wr_q.size();
        int lat;
        do_read(a, exp, 1'b0, lat);
        check("hit_latency", 32'(lat), 32'd2);
        check("hit_no_mem_req", 32'(memreq_cyc - mq), 32'd0);
        check("hit_no_write", 32'(wr_q.size() - wb), 32'd0);
    endtask

    initial begin
        bit got;
        reset          = 1'b1;
        bus_if.req_i   = 1'b0;
        bus_if.flush_i = 1'b0;
        bus_if.addr_i  = '0;
        repeat (2) @(posedge clk);

        do_reset("reset");
        miss_read(32'h0000_0014, 32'h0000_0022, 1'b0, 1'b0);
        hit_read (32'h0000_0018, 32'h0000_0033);
        miss_read(32'h0000_0410, 32'h0001_0011, 1'b1, 1'b0);
        miss_read(32'h0000_0810, 32'h0002_0011, 1'b0, 1'b0);
        hit_read (32'h0000_0410, 32'h0001_0011);

        delay_beat2 = 1'b1;
        miss_read(32'h0000_0C2C, 32'h0003_0044, 1'b0, 1'b0);
        delay_beat2 = 1'b0;
        hit_read (32'h0000_0C20, 32'h0003_0011);

        miss_read(32'h0000_0014, 32'h0000_0022, 1'b0, 1'b1);
        check("flush_busy_cycles", 32'(flush_clears), 32'd128);

        // Abort a refill with reset right after beat 1 is granted.
        @(posedge clk); #1;
        bus_if.req_i  = 1'b1;
        bus_if.addr_i = 32'h0000_1014;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk); #1;
            if (bus_if.gnt_o) got = 1'b1;
        end
        @(posedge clk); #1;
        bus_if.req_i = 1'b0;
        if (!got) fail_now("abort_gnt");
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk); #1;
            if (bus_if.mem_req_o && bus_if.mem_gnt_i && bus_if.mem_addr_o[3:2] == 2'd1) got = 1'b1;
        end
        if (!got) fail_now("abort_beat1");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_mem_req", 32'(bus_if.mem_req_o), 32'd0);
        check("abort_state_flush", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_idle("abort");

        miss_read(32'h0000_0014, 32'h0000_0022, 1'b0, 1'b0);
        miss_read(32'h0000_1014, 32'h0004_0022, 1'b1, 1'b0);
        hit_read (32'h0000_1018, 32'h0004_0033);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
